// File: rtl/program_loader.sv
// Writer side of the 16-entry instruction store: streams a program in over valid/ready,
// zero-fills the unused tail, and releases the CPU (cpu_run) once the image is complete.
module program_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_run,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   len;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  len_ok;
  logic                  transfer;
  logic [ADDR_WIDTH:0]   cnt_next;
  logic [ADDR_WIDTH-1:0] ptr_next;

  assign len_ok   = (length != '0) && (length <= DEPTH_CNT);
  assign transfer = in_valid && in_ready;
  assign cnt_next = words_loaded + CNT_ONE;
  assign ptr_next = ptr + PTR_ONE;

  // Fetch port: a same-edge write is seen only after that edge.
  assign rd_data = mem[rd_addr];

  // NOTE: the store has no reset; its contents must survive a reset pulse.
  always_ff @(posedge clk) begin
    if (state == LOAD && transfer) begin
      mem[ptr] <= in_data;
    end else if (state == FILL) begin
      mem[ptr] <= '0;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      len          <= '0;
      words_loaded <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_run      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (len_ok) begin
              len          <= length;
              ptr          <= '0;
              words_loaded <= '0;
              error        <= 1'b0;
              state        <= LOAD;
              in_ready     <= 1'b1;
              busy         <= 1'b1;
              done         <= 1'b0;
              cpu_run      <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (transfer) begin
            ptr          <= ptr_next;
            words_loaded <= cnt_next;
            if (cnt_next == len) begin
              in_ready <= 1'b0;
              // A full-depth image has no tail to clear.
              if (len == DEPTH_CNT) begin
                state   <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                cpu_run <= 1'b1;
              end else begin
                state <= FILL;
              end
            end
          end
        end

        FILL: begin
          ptr <= ptr_next;
          if (ptr == PTR_LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            cpu_run <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          cpu_run  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: handshake timing, tail zero-fill, illegal
// lengths, reload from DONE, reset mid-load, and start ignored while loading.
module tb_program_loader;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW:0]   length;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_run;
  logic [AW:0]   words_loaded;

  program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .length       (length),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cpu_run      (cpu_run),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [AW:0] len;
    logic        exp_error;
    logic        exp_busy;
    logic        exp_in_ready;
  } start_vec_t;

  exp_t       sb[$];
  start_vec_t start_tbl[4];
  int         n_vec = 0;
  int         n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are stable until the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW:0] len);
    start  = 1'b1;
    length = len;
    tick();
    start  = 1'b0;
    length = 5'd31;
  endtask

  // Offers n words base+i; a word is accepted at the edge where in_valid and in_ready are high.
  task automatic send_words(input int n, input bit toggle, input logic [DW-1:0] base,
                            input int first_addr, output int cycles);
    int  sent = 0;
    bit  ph = 1'b0;
    cycles = 0;
    while (sent < n && cycles < 200) begin
      in_valid = toggle ? ph : 1'b1;
      in_data  = base + DW'(sent);
      ph = ~ph;
      if (in_valid && in_ready) begin
        sb.push_back('{addr: AW'(first_addr + sent), data: in_data});
        sent++;
      end
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    if (sent < n) check("send_timeout", 32'(sent), 32'(n));
  endtask

  task automatic push_zeros(input int from);
    for (int a = from; a < DEPTH; a++) sb.push_back('{addr: AW'(a), data: '0});
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!done && c < 100) begin
      tick();
      c++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic drain_image(input string name);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.addr;
      #1;
      check($sformatf("%s[%0d]", name, e.addr), 32'(rd_data), 32'(e.data));
    end
  endtask

  initial begin
    int cyc;

    start_tbl[0] = '{len: 5'd0,  exp_error: 1'b1, exp_busy: 1'b0, exp_in_ready: 1'b0};
    start_tbl[1] = '{len: 5'd17, exp_error: 1'b1, exp_busy: 1'b0, exp_in_ready: 1'b0};
    start_tbl[2] = '{len: 5'd31, exp_error: 1'b1, exp_busy: 1'b0, exp_in_ready: 1'b0};
    start_tbl[3] = '{len: 5'd1,  exp_error: 1'b0, exp_busy: 1'b1, exp_in_ready: 1'b1};

    reset = 1'b0; start = 1'b0; length = '0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b1;
    tick();

    // Length 3, in_valid held high: 3 accept cycles, 13 fill cycles, then DONE.
    do_start(5'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'(16'h1111 * (i + 1));
      check($sformatf("t1_ready%0d", i), 32'(in_ready), 32'd1);
      sb.push_back('{addr: AW'(i), data: in_data});
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 13; c++) begin
      check($sformatf("t1_fill%0d", c), {29'd0, busy, in_ready, done}, {29'd0, 3'b100});
      tick();
    end
    check("t1_done", {30'd0, done, cpu_run}, 32'd3);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_words", 32'(words_loaded), 32'd3);
    push_zeros(3);
    drain_image("t1_mem");

    // Full-depth image with in_valid toggling: 32 offer cycles, DONE right after last transfer.
    do_start(5'd16);
    send_words(16, 1'b1, 16'hC000, 0, cyc);
    check("t2_cycles", 32'(cyc), 32'd32);
    check("t2_done", {30'd0, done, cpu_run}, 32'd3);
    check("t2_words", 32'(words_loaded), 32'd16);
    drain_image("t2_mem");

    // Illegal start in DONE: error set, still DONE.
    do_start(5'd0);
    check("done_illegal_err", 32'(error), 32'd1);
    check("done_illegal_stay", {30'd0, done, cpu_run}, 32'd3);

    // Reload from DONE: cpu_run falls next cycle, tail re-zeroed over the full image.
    do_start(5'd2);
    check("t4_cpu_run_low", 32'(cpu_run), 32'd0);
    check("t4_error_clr", 32'(error), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    in_valid = 1'b1; in_data = 16'hAAAA;
    sb.push_back('{addr: 4'd0, data: 16'hAAAA});
    tick();
    in_data = 16'hBBBB;
    sb.push_back('{addr: 4'd1, data: 16'hBBBB});
    tick();
    in_valid = 1'b0;
    wait_done("t4_wait_done");
    check("t4_cpu_run", 32'(cpu_run), 32'd1);
    check("t4_words", 32'(words_loaded), 32'd2);
    push_zeros(2);
    drain_image("t4_mem");

    // Back to IDLE, then table of start requests (illegal ones, then a legal one).
    reset = 1'b0; #2; reset = 1'b1;
    tick();
    foreach (start_tbl[i]) begin
      do_start(start_tbl[i].len);
      check($sformatf("tbl%0d_error", i), 32'(error), 32'(start_tbl[i].exp_error));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(start_tbl[i].exp_busy));
      check($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(start_tbl[i].exp_in_ready));
    end
    send_words(1, 1'b0, 16'h7777, 0, cyc);
    wait_done("t3_wait_done");
    check("t3_words", 32'(words_loaded), 32'd1);
    push_zeros(1);
    drain_image("t3_mem");

    // Reset after 2 of 5 words: outputs clear before the next edge, written words persist.
    do_start(5'd5);
    send_words(2, 1'b0, 16'h5A00, 0, cyc);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async", {27'd0, in_ready, busy, done, error, cpu_run}, 32'd0);
    check("t5_words", 32'(words_loaded), 32'd0);
    #3;
    reset = 1'b1;
    tick();
    drain_image("t5_keep");
    do_start(5'd4);
    send_words(4, 1'b0, 16'h4400, 0, cyc);
    wait_done("t5_wait_done");
    check("t5_new_words", 32'(words_loaded), 32'd4);
    push_zeros(4);
    drain_image("t5_mem");

    // start during LOAD with a different length is ignored.
    do_start(5'd4);
    send_words(1, 1'b0, 16'h6600, 0, cyc);
    do_start(5'd2);
    send_words(1, 1'b0, 16'h6601, 1, cyc);
    check("t6_still_load", {30'd0, busy, in_ready}, 32'd3);
    check("t6_not_done", 32'(done), 32'd0);
    send_words(2, 1'b0, 16'h6602, 2, cyc);
    wait_done("t6_wait_done");
    check("t6_words", 32'(words_loaded), 32'd4);
    push_zeros(4);
    drain_image("t6_mem");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
